ifetch_pc_unit: RTL and testbench
=================================

Name: ifetch_pc_unit

Overview:
- Instruction fetch and next-PC stage directly upstream of ControlUnit in the MIPS core.
- Owns the PC register and runs a req/ready handshake to instruction memory.
- Holds the fetched word in an instruction register and presents it for one execute window.
- Consumes ControlUnit's branch/jump strobes plus ALU zero and rs data to select the next PC; exports the link address for jal/jalr.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  fetch request, high while in FETCH
- imem_addr  out  32  fetch address, equals pc
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  memory returns word this cycle
- instr  out  32  instruction register, drives op/func/rt decode
- instr_valid  out  1  high in EXEC
- pc  out  32  current PC
- link_addr  out  32  pc+4, write data for jal/jalr
- pcW  in  1  PC write enable from ControlUnit; 0 = stall in EXEC
- Branch_be, Branch_bn, Bgez, Bgtz, Blez, Bltz, Jump, Jal, Jr, Jalr  in  1 each  decoded control strobes
- zero  in  1  ALU zero flag (rs==rt compare)
- rs_data  in  32  register-file rs value
- addr_err  out  1  sticky misaligned-target flag
- retired  out  CNT_W  count of executed instructions

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC, state=IDLE, instr=0.
  - instr_valid=0, imem_req=0, addr_err=0, retired=0.
  - Reset wins over every other event, including mid-FETCH and mid-EXEC; an outstanding fetch is abandoned.
- Moore FSM:
  - IDLE: always -> FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=pc. If imem_ready=1, instr<=imem_rdata and go to EXEC; otherwise stay. Unbounded wait states are allowed.
  - EXEC: instr_valid=1; decode is combinational from instr. If pcW=1: pc<=next_pc, retired<=retired+1 (wraps modulo 2^CNT_W), go to FETCH. If pcW=0: hold pc, instr, retired; stay in EXEC.
  - HALT: entered from EXEC when pcW=1 and next_pc[1:0]!=0. pc and retired are not updated. addr_err=1, imem_req=0, instr_valid=0. Exit only by reset.
- Outputs are decoded from registered state only. imem_addr=pc in all states; link_addr=pc+4 (no delay slot).
- Minimum instruction period is 2 cycles (FETCH with ready, then EXEC).
- next_pc selection, highest priority first:
  1. Jr or Jalr: rs_data.
  2. Jump or Jal: {pc_plus4[31:28], instr[25:0], 2'b00}.
  3. Branch taken: pc_plus4 + (sign_extend(instr[15:0]) << 2), modulo 2^32.
  4. Otherwise: pc_plus4.
- Branch taken conditions:
  - Branch_be & zero
  - Branch_bn & ~zero
  - Bgez & ~rs_data[31]
  - Bgtz & ~rs_data[31] & (rs_data!=0)
  - Blez & (rs_data[31] | rs_data==0)
  - Bltz & rs_data[31]
- Multiple strobes asserted together resolve by the priority above.
- PC arithmetic wraps at 32 bits with no error: 32'hFFFF_FFFC + 4 = 0.
- Strobes and zero/rs_data are sampled only in EXEC with pcW=1; they are ignored elsewhere.
- imem_ready outside FETCH is ignored; instr does not change.

Test Plan:
- Reset, ready tied 1: IDLE, then fetch at 0x3000; instr_valid pulses every 2nd cycle; imem_addr = 0x3000, 0x3004, 0x3008; retired=3 after third EXEC.
- imem_ready delayed 3 cycles at 0x3004: imem_req held 3 cycles with addr stable; instr updates only on the ready cycle; no PC change during the wait.
- beq at pc=0x3010, imm=0xFFFE: zero=1 gives next addr 0x300C; zero=0 gives 0x3014. bltz with rs=0x8000_0000 taken; bgtz with rs=0 not taken.
- jal at pc=0x3020, target field 0x0000C10: link_addr=0x3024, next fetch 0x3040. jr with rs_data=0x0000_3100 gives next fetch 0x3100. Jr and Branch_be both asserted: Jr wins.
- jr with rs_data=0x3102: enters HALT, addr_err=1, imem_req=0, pc stays at the jr address; holds until rst_n=0, after which pc=0x3000 and addr_err=0.
- pcW=0 for 4 EXEC cycles: instr_valid held, pc/retired unchanged. rst_n low mid-FETCH with ready pending: next cycle state=IDLE, pc=0x3000, and the pending ready is ignored.

Source files
------------

// File: rtl/ifetch_pc_unit.sv
// Instruction fetch / next-PC stage: owns the PC, fetches over a req/ready port,
// holds the word for one execute window and resolves branch/jump targets.
module ifetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      link_addr,
    input  logic             pcW,
    input  logic             Branch_be,
    input  logic             Branch_bn,
    input  logic             Bgez,
    input  logic             Bgtz,
    input  logic             Blez,
    input  logic             Bltz,
    input  logic             Jump,
    input  logic             Jal,
    input  logic             Jr,
    input  logic             Jalr,
    input  logic             zero,
    input  logic [31:0]      rs_data,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic [31:0]        pc_plus4;
    logic signed [31:0] br_offset;
    logic               rs_neg;
    logic               rs_is_zero;
    logic               branch_taken;
    logic [31:0]        next_pc;

    assign pc_plus4   = pc_q + 32'd4;
    assign br_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign rs_neg     = rs_data[31];
    assign rs_is_zero = (rs_data == 32'd0);

    always_comb begin
        branch_taken = (Branch_be & zero)
                     | (Branch_bn & ~zero)
                     | (Bgez & ~rs_neg)
                     | (Bgtz & ~rs_neg & ~rs_is_zero)
                     | (Blez & (rs_neg | rs_is_zero))
                     | (Bltz & rs_neg);

        if (Jr || Jalr)
            next_pc = rs_data;
        else if (Jump || Jal)
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        else if (branch_taken)
            next_pc = pc_plus4 + br_offset;
        else
            next_pc = pc_plus4;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // A misaligned target halts without committing the PC or the count.
                if (pcW) begin
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = HALT;
                    end else begin
                        pc_d      = next_pc;
                        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d   = FETCH;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == EXEC);
    assign pc          = pc_q;
    assign link_addr   = pc_plus4;
    assign addr_err    = (state_q == HALT);
    assign retired     = retired_q;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Directed bench for ifetch_pc_unit: fetch timing, wait states, stalls,
// next-PC selection, misaligned-target halt and reset behaviour.
module tb_ifetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        pcW;
    logic        Branch_be, Branch_bn, Bgez, Bgtz, Blez, Bltz, Jump, Jal, Jr, Jalr;
    logic        zero;
    logic [31:0] rs_data;
    logic        addr_err;
    logic [31:0] retired;

    int n_cmp = 0;
    int n_err = 0;

    ifetch_pc_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .link_addr(link_addr), .pcW(pcW),
        .Branch_be(Branch_be), .Branch_bn(Branch_bn), .Bgez(Bgez), .Bgtz(Bgtz),
        .Blez(Blez), .Bltz(Bltz), .Jump(Jump), .Jal(Jal), .Jr(Jr), .Jalr(Jalr),
        .zero(zero), .rs_data(rs_data),
        .addr_err(addr_err), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        Branch_be = 0; Branch_bn = 0; Bgez = 0; Bgtz = 0; Blez = 0;
        Bltz = 0; Jump = 0; Jal = 0; Jr = 0; Jalr = 0;
        zero = 0; rs_data = 32'd0;
    endtask

    // From FETCH: return a word with ready, land in EXEC.
    task automatic fetch(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
    endtask

    // From EXEC with strobes set: commit and clear strobes.
    task automatic retire();
        pcW = 1'b1;
        step();
        clear_ctl();
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; pcW = 1'b1;
        clear_ctl();
        step(); step();
        chk("rst_pc", pc, 32'h3000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        chk("rst_retired", retired, 32'd0);

        // Ready tied high: IDLE, then back-to-back 2-cycle instructions.
        rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'd0;
        step();
        chk("f0_req", {31'd0, imem_req}, 32'd1);
        chk("f0_addr", imem_addr, 32'h3000);
        step();
        chk("e0_valid", {31'd0, instr_valid}, 32'd1);
        chk("e0_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("f1_addr", imem_addr, 32'h3004);
        chk("f1_valid", {31'd0, instr_valid}, 32'd0);
        step(); step();
        chk("f2_addr", imem_addr, 32'h3008);
        step(); step();
        chk("f3_retired", retired, 32'd3);
        chk("f3_addr", imem_addr, 32'h300C);

        // Three wait states at 0x300C.
        imem_ready = 1'b0; imem_rdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h300C);
            chk("wait_instr", instr, 32'd0);
        end
        fetch(32'h2222_2222);
        chk("ready_instr", instr, 32'h2222_2222);

        // Stall in EXEC for four cycles; ready during EXEC is ignored.
        pcW = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h3333_3333;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, 32'h300C);
            chk("stall_ret", retired, 32'd3);
            chk("stall_instr", instr, 32'h2222_2222);
        end
        imem_ready = 1'b0;
        retire();
        chk("post_stall_pc", pc, 32'h3010);
        chk("post_stall_ret", retired, 32'd4);

        // beq taken at 0x3010, imm -2: 0x3014 - 8 = 0x300C.
        fetch(32'h1000_FFFE);
        chk("beq_link", link_addr, 32'h3014);
        Branch_be = 1; zero = 1;
        retire();
        chk("beq_taken", imem_addr, 32'h300C);
        // beq not taken at 0x300C.
        fetch(32'h1000_FFFE);
        Branch_be = 1; zero = 0;
        retire();
        chk("beq_not", imem_addr, 32'h3010);
        // bltz taken at 0x3010, imm 3: 0x3014 + 12 = 0x3020.
        fetch(32'h0400_0003);
        Bltz = 1; rs_data = 32'h8000_0000;
        retire();
        chk("bltz_taken", imem_addr, 32'h3020);
        // jal at 0x3020, target field 0xC10.
        fetch(32'h0C00_0C10);
        chk("jal_link", link_addr, 32'h3024);
        Jal = 1;
        retire();
        chk("jal_target", imem_addr, 32'h3040);
        // bgtz with rs=0 not taken.
        fetch(32'h1C00_0010);
        Bgtz = 1; rs_data = 32'd0;
        retire();
        chk("bgtz_not", imem_addr, 32'h3044);
        // jr with a taken branch strobe also set: jr wins.
        fetch(32'h03E0_0008);
        Jr = 1; rs_data = 32'h0000_3100; Branch_be = 1; zero = 1;
        retire();
        chk("jr_prio", imem_addr, 32'h3100);
        chk("jr_ret", retired, 32'd10);

        // Misaligned jr target halts.
        fetch(32'h03E0_0008);
        Jr = 1; rs_data = 32'h0000_3102;
        retire();
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("halt_err", {31'd0, addr_err}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_pc", pc, 32'h3100);
            chk("halt_ret", retired, 32'd10);
            step();
        end
        rst_n = 1'b0; imem_ready = 1'b0;
        step();
        chk("halt_rst_pc", pc, 32'h3000);
        chk("halt_rst_err", {31'd0, addr_err}, 32'd0);

        // PC wraps past 0xFFFF_FFFC.
        rst_n = 1'b1;
        step();
        fetch(32'h03E0_0008);
        Jr = 1; rs_data = 32'hFFFF_FFFC;
        retire();
        chk("wrap_hi", pc, 32'hFFFF_FFFC);
        fetch(32'd0);
        chk("wrap_link", link_addr, 32'd0);
        retire();
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_err", {31'd0, addr_err}, 32'd0);

        // Reset mid-FETCH with ready pending: the fetch is abandoned.
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hABCD_1234;
        step();
        chk("mid_req0", {31'd0, imem_req}, 32'd0);
        chk("mid_pc", pc, 32'h3000);
        chk("mid_instr", instr, 32'd0);
        chk("mid_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_ret", retired, 32'd0);
        rst_n = 1'b1; imem_ready = 1'b0;
        step();
        chk("mid_refetch", {31'd0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
